ioc_spi_master: RTL and testbench
=================================

Name: ioc_spi_master

Overview:
- SPI slave front end for the host link. Turns each host SPI frame into one fetch or load strobe on the internal IOC register bus.
- It is the initiator end of that bus. It drives the ioc address, write data, per-module chip select and the fetch/load strobes. Responder modules (io_ctrl, sys_ctrl, ...) return read data on their data-out buses.
- Sits between the top-level SPI pins and all IOC responders.

Parameters:
- NUM_MODULES, 4: number of IOC responders. Range 1..4.

Ports:
- i_sys_clk  in  1  system clock; must be at least 16x the SCK frequency.
- i_rst_b  in  1  asynchronous, active-low reset.
- i_spi_sck  in  1  host SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to i_sys_clk.
- i_spi_mosi  in  1  host data to block.
- i_spi_cs_b  in  1  host frame select, active low.
- o_spi_miso  out  1  read data to host, MSB first.
- o_ioc  out  5  register address to responders.
- o_data_out  out  8  write data to responders.
- i_rd_data  in  8*NUM_MODULES  concatenated responder read data; module k occupies bits [8k+7:8k].
- o_cs  out  NUM_MODULES  one-hot module select.
- o_fetch_cmd  out  1  read strobe, one cycle wide.
- o_load_cmd  out  1  write strobe, one cycle wide.
- o_busy  out  1  high while a frame is in progress (state other than IDLE).

Behaviour:
- Reset (asynchronous, i_rst_b=0): all outputs 0 (o_cs=0, strobes=0, o_ioc=0, o_data_out=0, o_spi_miso=0). FSM goes to IDLE. Bit counter and shift registers are cleared.
- Synchronisation:
  - SCK, MOSI and CS_b each pass through a 2-FF synchroniser into i_sys_clk.
  - SCK rising and falling edges are detected on the synchronised signal.
  - MOSI is sampled on the detected rising edge.
  - MISO changes only on detected falling edges, plus the initial preload in CAPTURE.
- Frame format, MSB first, 16 SCK cycles:
  - Byte 0 = command: bit7 W (1 = write, 0 = read), bits6:5 module select SEL, bits4:0 IOC.
  - Byte 1 = write data (write), or don't-care MOSI while the block shifts read data out (read).
- FSM states:
  - IDLE: wait for synchronised CS_b falling → CMD. Bit counter = 0, o_spi_miso = 0.
  - CMD: shift 8 bits. On the 8th rising edge, latch o_ioc = cmd[4:0]. Then:
    - read → FETCH;
    - write → DATA.
  - FETCH: one cycle. o_fetch_cmd=1 and o_cs[SEL]=1 in the same cycle → CAPTURE.
  - CAPTURE: one cycle. Latch i_rd_data[8*SEL+:8] into the TX shift register (the responder registers its data at the end of the FETCH cycle). Drive o_spi_miso = bit7 immediately → DATA.
  - DATA: shift 8 bits.
    - Read: advance MISO on each falling edge after the first.
    - Write: capture MOSI on rising edges.
    - On the 16th rising edge: write → LOAD; read → DONE.
  - LOAD: one cycle. o_data_out = captured byte, o_load_cmd=1, o_cs[SEL]=1 → DONE.
  - DONE: o_spi_miso=0. Ignore further SCK. Return to IDLE on CS_b rising.
- Strobes and o_cs:
  - o_cs is nonzero only in the FETCH and LOAD cycles.
  - o_fetch_cmd and o_load_cmd are never high together.
  - o_ioc and o_data_out hold their last values between frames.
- Latency:
  - Fetch is issued 3-4 sys clocks after the 8th physical SCK rise.
  - MISO bit7 is valid by cycle 5–6, before the first SCK rise of byte 1 (guaranteed by the 16x ratio).
  - Load is issued 3-4 clocks after the 16th rise.
- Out-of-range SEL (SEL ≥ NUM_MODULES):
  - no o_cs bit set and no strobe issued;
  - a read returns 0x00 on MISO;
  - a write is discarded.
- CS_b deasserted in any state other than IDLE/DONE:
  - abort to IDLE, no load strobe;
  - an already-issued fetch has no further effect;
  - partial bytes are discarded.
- CS_b reasserting in the same cycle as the DONE exit is seen as a new frame on the next cycle.
- Reset mid-frame: immediate return to IDLE with reset values; the host frame is lost.
- Extra SCK cycles beyond 16 are ignored, with MISO held 0.

Test Plan:
- Write frame 0x81,0x03 (W=1, SEL=0, IOC=1) → exactly one o_load_cmd pulse with o_cs=0001, o_ioc=00001, o_data_out=0x03; o_fetch_cmd stays 0.
- Read frame 0x22,0xXX with i_rd_data[15:8]=0xA5 → one o_fetch_cmd pulse with o_cs=0010, o_ioc=00010; host shifts in 0xA5.
- NUM_MODULES=2, read frame 0x60 (SEL=3) → no strobe, o_cs=00, MISO returns 0x00. Write frame 0xE0,0x55 → no load pulse.
- Write frame CS_b deasserted after 12 SCK → FSM back in IDLE, no o_load_cmd. A following valid write 0x84,0x7F completes normally with o_data_out=0x7F.
- i_rst_b pulled low asynchronously mid-DATA, between clock edges → outputs 0 immediately. After release, a read 0x00 returns the responder's version byte.
- Back-to-back frames at the 16x sys/SCK ratio with 2-clock CS_b high gaps, alternating read/write → every frame produces exactly one correct strobe; no dropped or merged transactions.

Source files
------------

// File: rtl/ioc_spi_master.sv
// ioc_spi_master: SPI mode-0 slave front end that turns each 16-bit host frame
// into exactly one fetch or load strobe on the internal IOC register bus.
module ioc_spi_master #(
    parameter int NUM_MODULES = 4
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst_b,
    input  logic                     i_spi_sck,
    input  logic                     i_spi_mosi,
    input  logic                     i_spi_cs_b,
    output logic                     o_spi_miso,
    output logic [4:0]               o_ioc,
    output logic [7:0]               o_data_out,
    input  logic [8*NUM_MODULES-1:0] i_rd_data,
    output logic [NUM_MODULES-1:0]   o_cs,
    output logic                     o_fetch_cmd,
    output logic                     o_load_cmd,
    output logic                     o_busy,
    output logic [2:0]               o_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        FETCH   = 3'd2,
        CAPTURE = 3'd3,
        DATA    = 3'd4,
        LOAD    = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sck_q;
    logic [1:0]  mosi_q;
    logic [2:0]  csb_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        miso_q, miso_d;
    logic [4:0]  ioc_q, ioc_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic [1:0]  sel_q, sel_d;

    logic        sck_rise, sck_fall, cs_fall, csb_s, mosi_s, sel_ok;
    logic [7:0]  rx_shift, rd_byte;

    // Two flops of synchronisation, third SCK/CS_b stage feeds the edge detectors.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sck_q  <= 3'b000;
            mosi_q <= 2'b00;
            csb_q  <= 3'b111;
        end else begin
            sck_q  <= {sck_q[1:0], i_spi_sck};
            mosi_q <= {mosi_q[0], i_spi_mosi};
            csb_q  <= {csb_q[1:0], i_spi_cs_b};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~csb_q[1] & csb_q[2];
    assign csb_s    = csb_q[1];
    assign mosi_s   = mosi_q[1];
    assign rx_shift = {rx_q[6:0], mosi_s};
    assign sel_ok   = ({30'd0, sel_q} < 32'(NUM_MODULES));

    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < NUM_MODULES; k++) begin
            if (sel_q == 2'(k)) rd_byte = i_rd_data[8*k +: 8];
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rx_q    <= 8'h00;
            tx_q    <= 8'h00;
            miso_q  <= 1'b0;
            ioc_q   <= 5'd0;
            dout_q  <= 8'h00;
            wr_q    <= 1'b0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            miso_q  <= miso_d;
            ioc_q   <= ioc_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        ioc_d   = ioc_q;
        dout_d  = dout_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                cnt_d  = 4'd0;
                miso_d = 1'b0;
                if (cs_fall) state_d = CMD;
            end
            CMD: begin
                if (sck_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        wr_d    = rx_shift[7];
                        sel_d   = rx_shift[6:5];
                        ioc_d   = rx_shift[4:0];
                        state_d = rx_shift[7] ? DATA : FETCH;
                    end
                end
            end
            FETCH: state_d = CAPTURE;
            CAPTURE: begin
                tx_d    = rd_byte;
                miso_d  = rd_byte[7];
                state_d = DATA;
            end
            DATA: begin
                if (sck_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (wr_q) begin
                            state_d = LOAD;
                            if (sel_ok) dout_d = rx_shift;
                        end else begin
                            state_d = DONE;
                            miso_d  = 1'b0;
                        end
                    end
                // The falling edge that ends the command byte must keep bit7 on the line.
                end else if (sck_fall && !wr_q && cnt_q > 4'd8) begin
                    tx_d   = {tx_q[6:0], 1'b0};
                    miso_d = tx_q[6];
                end
            end
            LOAD: state_d = DONE;
            DONE: begin
                miso_d = 1'b0;
                if (csb_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (csb_s && (state_q inside {CMD, FETCH, CAPTURE, DATA, LOAD})) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            miso_d  = 1'b0;
        end
    end

    always_comb begin
        o_cs = '0;
        if (state_q == FETCH || state_q == LOAD) begin
            for (int k = 0; k < NUM_MODULES; k++) begin
                if (sel_q == 2'(k)) o_cs[k] = 1'b1;
            end
        end
    end

    assign o_fetch_cmd = (state_q == FETCH) && sel_ok;
    assign o_load_cmd  = (state_q == LOAD) && sel_ok;
    assign o_spi_miso  = miso_q;
    assign o_ioc       = ioc_q;
    assign o_data_out  = dout_q;
    assign o_busy      = (state_q != IDLE);
    assign o_state     = state_q;

endmodule

// File: tb/tb_ioc_spi_master.sv
// Bench for ioc_spi_master: drives host SPI frames into a 4-module and a
// 2-module instance and scores bus strobes and MISO bytes against a frame model.
module tb_ioc_spi_master;

    localparam int HALF = 80;  // half SCK period in ns; sys clock period is 10 ns

    typedef struct packed {
        logic        has_ev;
        logic [17:0] ev;       // {is_load, ioc[4:0], cs[3:0], data[7:0]}
        logic [7:0]  miso;
    } ref_t;

    logic        clk, rst_b, sck, mosi, cs_b;
    logic [31:0] rd_data;
    logic        miso, fetch, load, busy;
    logic [4:0]  ioc;
    logic [7:0]  dout;
    logic [3:0]  cs;
    logic [2:0]  state;
    logic        miso2, fetch2, load2, busy2;
    logic [4:0]  ioc2;
    logic [7:0]  dout2;
    logic [1:0]  cs2;
    logic [2:0]  state2;

    logic [17:0] exp_q[$], obs_q[$], exp2_q[$], obs2_q[$];
    int n_checks = 0;
    int n_bad = 0;
    int proto_err = 0;

    ioc_spi_master #(.NUM_MODULES(4)) dut (
        .i_sys_clk(clk), .i_rst_b(rst_b), .i_spi_sck(sck), .i_spi_mosi(mosi),
        .i_spi_cs_b(cs_b), .o_spi_miso(miso), .o_ioc(ioc), .o_data_out(dout),
        .i_rd_data(rd_data), .o_cs(cs), .o_fetch_cmd(fetch), .o_load_cmd(load),
        .o_busy(busy), .o_state(state)
    );

    ioc_spi_master #(.NUM_MODULES(2)) dut2 (
        .i_sys_clk(clk), .i_rst_b(rst_b), .i_spi_sck(sck), .i_spi_mosi(mosi),
        .i_spi_cs_b(cs_b), .o_spi_miso(miso2), .o_ioc(ioc2), .o_data_out(dout2),
        .i_rd_data(rd_data[15:0]), .o_cs(cs2), .o_fetch_cmd(fetch2), .o_load_cmd(load2),
        .o_busy(busy2), .o_state(state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bus monitor
    always @(negedge clk) begin
        if (fetch) obs_q.push_back({1'b0, ioc, cs, 8'h00});
        if (load)  obs_q.push_back({1'b1, ioc, cs, dout});
        if (fetch2) obs2_q.push_back({1'b0, ioc2, 2'b00, cs2, 8'h00});
        if (load2)  obs2_q.push_back({1'b1, ioc2, 2'b00, cs2, dout2});
        if ((fetch && load) || (fetch2 && load2)) proto_err++;
        if ((cs != 4'd0 && !(fetch || load)) || (cs2 != 2'd0 && !(fetch2 || load2))) proto_err++;
    end

    // Frame model: one strobe for an in-range module, read byte returned on MISO.
    function automatic ref_t ref_frame(input logic [7:0] cmd, input logic [7:0] data,
                                       input int n_mod, input logic [31:0] rd);
        ref_t r;
        int sel;
        logic [31:0] sh;
        logic [3:0] onehot;
        sel = int'(cmd[6:5]);
        onehot = 4'b0001 << sel;
        sh = rd >> (8 * sel);
        r.has_ev = (sel < n_mod);
        if (cmd[7]) begin
            r.ev = {1'b1, cmd[4:0], onehot, data};
            r.miso = 8'h00;
        end else begin
            r.ev = {1'b0, cmd[4:0], onehot, 8'h00};
            r.miso = r.has_ev ? sh[7:0] : 8'h00;
        end
        return r;
    endfunction

    // driver: host frame, MISO sampled just before each SCK rise
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                             input int gap, output logic [31:0] m1, output logic [31:0] m2);
        logic [15:0] word;
        word = {cmd, data};
        m1 = 32'd0;
        m2 = 32'd0;
        cs_b = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'($urandom_range(0, 1));
            #HALF;
            m1 = {m1[30:0], miso};
            m2 = {m2[30:0], miso2};
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        #HALF;
        cs_b = 1'b1;
        mosi = 1'b0;
        #gap;
    endtask

    // scoreboard
    task automatic scoreboard(input string name);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s dut4 strobe count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end else begin
            while (exp_q.size() > 0) begin
                logic [17:0] o, e;
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL %s dut4 strobe {ld,ioc,cs,data}: got %h want %h", name, o, e);
                end
            end
        end
        n_checks++;
        if (obs2_q.size() != exp2_q.size()) begin
            n_bad++;
            $display("FAIL %s dut2 strobe count: got %0d want %0d", name, obs2_q.size(), exp2_q.size());
        end else begin
            while (exp2_q.size() > 0) begin
                logic [17:0] o, e;
                o = obs2_q.pop_front();
                e = exp2_q.pop_front();
                n_checks++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL %s dut2 strobe {ld,ioc,cs,data}: got %h want %h", name, o, e);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
        obs2_q.delete();
        exp2_q.delete();
    endtask

    task automatic do_frame(input string name, input logic [7:0] cmd, input logic [7:0] data,
                            input int nbits, input int gap);
        ref_t r1, r2;
        logic [31:0] m1, m2, e1, e2;
        r1 = ref_frame(cmd, data, 4, rd_data);
        r2 = ref_frame(cmd, data, 2, {16'h0000, rd_data[15:0]});
        if (nbits >= 16) begin
            if (r1.has_ev) exp_q.push_back(r1.ev);
            if (r2.has_ev) exp2_q.push_back(r2.ev);
        end
        run_frame(cmd, data, nbits, gap, m1, m2);
        if (nbits >= 16) begin
            e1 = 32'(r1.miso) << (nbits - 16);
            e2 = 32'(r2.miso) << (nbits - 16);
            n_checks++;
            if (m1 !== e1) begin
                n_bad++;
                $display("FAIL %s dut4 miso bits: got %h want %h", name, m1, e1);
            end
            n_checks++;
            if (m2 !== e2) begin
                n_bad++;
                $display("FAIL %s dut2 miso bits: got %h want %h", name, m2, e2);
            end
        end
        scoreboard(name);
    endtask

    task automatic test_reset();
        logic [27:0] got;
        rst_b = 1'b0;
        sck = 1'b0;
        mosi = 1'b0;
        cs_b = 1'b1;
        rd_data = 32'd0;
        #23;
        got = {miso, ioc, dout, cs, fetch, load, busy, state, miso2, busy2, cs2, state2};
        n_checks++;
        if (got !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_in outputs: got %h want 0", got);
        end
        #10;
        rst_b = 1'b1;
        #30;
        got = {miso, ioc, dout, cs, fetch, load, busy, state, miso2, busy2, cs2, state2};
        n_checks++;
        if (got !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_out outputs: got %h want 0", got);
        end
    endtask

    task automatic test_write();
        rd_data = $urandom;
        do_frame("write81", 8'h81, 8'h03, 16, 200);
        n_checks++;
        if ({ioc, dout} !== {5'd1, 8'h03}) begin
            n_bad++;
            $display("FAIL write_hold ioc/data: got %h/%h want 01/03", ioc, dout);
        end
    endtask

    task automatic test_read();
        rd_data = $urandom;
        rd_data[15:8] = 8'hA5;
        do_frame("read22", 8'h22, 8'($urandom), 16, 200);
        n_checks++;
        if (ioc !== 5'd2) begin
            n_bad++;
            $display("FAIL read_ioc: got %h want 02", ioc);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] d2_before;
        rd_data = $urandom;
        d2_before = dout2;
        do_frame("read60", 8'h60, 8'($urandom), 16, 200);
        do_frame("writeE0", 8'hE0, 8'h55, 16, 200);
        n_checks++;
        if (dout2 !== d2_before) begin
            n_bad++;
            $display("FAIL oor_discard dut2 data_out: got %h want %h", dout2, d2_before);
        end
        n_checks++;
        if (dout !== 8'h55) begin
            n_bad++;
            $display("FAIL oor_inrange dut4 data_out: got %h want 55", dout);
        end
    endtask

    task automatic test_abort();
        logic [7:0] d_before;
        d_before = dout;
        do_frame("abort12", 8'h81, 8'hF0, 12, 200);
        n_checks++;
        if ({busy, state, dout} !== {1'b0, 3'd0, d_before}) begin
            n_bad++;
            $display("FAIL abort_idle busy/state/data: got %b/%0d/%h want 0/0/%h",
                     busy, state, dout, d_before);
        end
        do_frame("write84", 8'h84, 8'h7F, 16, 200);
        n_checks++;
        if ({ioc, dout} !== {5'd4, 8'h7F}) begin
            n_bad++;
            $display("FAIL abort_next ioc/data: got %h/%h want 04/7f", ioc, dout);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] word;
        logic [23:0] got;
        word = 16'h853C;
        cs_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mosi = word[15-i];
            #HALF;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        n_checks++;
        if ({busy, ioc} !== {1'b1, 5'd5}) begin
            n_bad++;
            $display("FAIL midframe busy/ioc: got %b/%h want 1/05", busy, ioc);
        end
        #3;
        rst_b = 1'b0;
        #1;
        got = {miso, ioc, dout, cs, fetch, load, busy, state};
        n_checks++;
        if (got !== 24'd0) begin
            n_bad++;
            $display("FAIL async_reset outputs: got %h want 0", got);
        end
        #16;
        cs_b = 1'b1;
        mosi = 1'b0;
        #40;
        rst_b = 1'b1;
        #40;
        rd_data = $urandom;
        rd_data[7:0] = 8'h5A;
        do_frame("version", 8'h00, 8'($urandom), 16, 200);
    endtask

    task automatic test_extra_sck();
        rd_data = $urandom;
        do_frame("extra_sck", 8'h41, 8'($urandom), 20, 200);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] cmd;
            cmd = {1'(i % 2), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
            rd_data = $urandom;
            do_frame($sformatf("b2b%0d", i), cmd, 8'($urandom), 16, 20);
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (proto_err !== 0) begin
            n_bad++;
            $display("FAIL protocol cs/strobe violations: got %0d want 0", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_abort();
        test_reset_mid();
        test_extra_sck();
        test_back_to_back();
        test_protocol();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
